dma_bar_resp: RTL and testbench

DMA_BAR_RESP -- requirements
Module: dma_bar_resp

---
 rtl/dma_bar_resp_pkg.sv | 13 +
 rtl/dma_os_cnt.sv | 33 +++
 rtl/dma_bar_resp.sv | 123 ++++++++++++
 tb/tb_dma_bar_resp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_bar_resp_pkg.sv
// Shared configuration defaults and type definitions for the DMA barrier responder.
// pygmy_cfg is also consumed by the barrier arbiter.
package pygmy_cfg;
  localparam int DMA_THREAD_CNT_DEF = 4;
endpackage

package pygmy_typedef;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } dma_bar_resp_state_e;
endpackage

// File: rtl/dma_os_cnt.sv
// Saturating outstanding-transaction counter.
// Flags full and an ignored decrement at zero.
module dma_os_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         underflow
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  assign full      = (cnt == MAX);
  assign underflow = dec && !inc && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({inc, dec})
        2'b10: if (!full) cnt <= cnt + ONE;
        2'b01: if (!underflow) cnt <= cnt - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_bar_resp.sv
// Memory-barrier responder: drains outstanding DMA requests, then pulses bar_done.
// Optional drain watchdog enabled by DMA_BAR_TIMEOUT_EN.
module dma_bar_resp
  import pygmy_cfg::*;
  import pygmy_typedef::*;
#(
  parameter int DMA_THREAD_CNT = DMA_THREAD_CNT_DEF,
  parameter int OS_CNT_W       = 6,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DMA_THREAD_CNT-1:0] bar_req,
  output logic [DMA_THREAD_CNT-1:0] bar_done,
  input  logic                      mem_issue,
  output logic                      mem_issue_rdy,
  input  logic                      mem_rsp,
  output logic [OS_CNT_W-1:0]       os_cnt,
  output logic [1:0]                err
);

  localparam int TID_W =
    (DMA_THREAD_CNT > 1) ? $clog2(DMA_THREAD_CNT) : 1;

  dma_bar_resp_state_e state_q, state_d;
  logic [TID_W-1:0]    tid_q;
  logic [TID_W-1:0]    req_idx;
  logic                cnt_full;
  logic                cnt_uf;
  logic                uf_q;
  logic                wd_hit;

  dma_os_cnt #(
    .W (OS_CNT_W)
  ) u_os_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (mem_issue),
    .dec       (mem_rsp),
    .cnt       (os_cnt),
    .full      (cnt_full),
    .underflow (cnt_uf)
  );

  // Descending scan so the lowest set bit wins.
  always_comb begin
    req_idx = '0;
    for (int i = DMA_THREAD_CNT - 1; i >= 0; i--) begin
      if (bar_req[i]) req_idx = TID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bar_req) state_d = DRAIN;
      DRAIN:   if (os_cnt == '0 || wd_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bar_done = '0;
    if (state_q == DONE) bar_done[tid_q] = 1'b1;
  end

  assign mem_issue_rdy = (state_q == IDLE) && !cnt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tid_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |bar_req) tid_q <= req_idx;
      if (cnt_uf) uf_q <= 1'b1;
    end
  end

`ifdef DMA_BAR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q;
  logic            to_q;

  assign wd_hit = (state_q == DRAIN) && (wd_q == WD_W'(TIMEOUT_CYC));

  // Watchdog restarts every time DRAIN is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (state_q != DRAIN) wd_q <= '0;
      else if (!wd_hit) wd_q <= wd_q + WD_W'(1);
      if (wd_hit && os_cnt != '0) to_q <= 1'b1;
    end
  end

  assign err = {to_q, uf_q};
`else
  assign wd_hit = 1'b0;
  assign err    = {1'b0, uf_q};
`endif

`ifndef SYNTHESIS
  a_issue_rdy: assert property (@(posedge clk) disable iff (rst)
    mem_issue |-> mem_issue_rdy);
  a_req_idle: assert property (@(posedge clk) disable iff (rst)
    (|bar_req) |-> (state_q == IDLE));
  a_req_1hot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bar_req));
  a_done_1hot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bar_done));
  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({bar_done, mem_issue_rdy, os_cnt, err}));
  a_cfg: assert property (@(posedge clk) disable iff (rst)
    TIMEOUT_CYC > 0);
`endif

endmodule

// File: tb/tb_dma_bar_resp.sv
// Scoreboard bench for dma_bar_resp: expected bar_done pulses are queued by the
// stimulus and popped by a negedge monitor; status outputs are checked inline.
module tb_dma_bar_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bar_req;
  logic [3:0] bar_done;
  logic       mem_issue;
  logic       mem_issue_rdy;
  logic       mem_rsp;
  logic [5:0] os_cnt;
  logic [1:0] err;

  typedef struct {
    int         cyc;
    logic [3:0] done;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dma_bar_resp #(
    .DMA_THREAD_CNT (4),
    .OS_CNT_W       (6),
    .TIMEOUT_CYC    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bar_req       (bar_req),
    .bar_done      (bar_done),
    .mem_issue     (mem_issue),
    .mem_issue_rdy (mem_issue_rdy),
    .mem_rsp       (mem_rsp),
    .os_cnt        (os_cnt),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bar_done !== 4'b0000) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexp: got %b at cyc %0d, required none",
                 bar_done, cyc);
      end else begin
        e = q.pop_front();
        if (bar_done !== e.done || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL done: got %b at cyc %0d, required %b at cyc %0d",
                   bar_done, cyc, e.done, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic cyc1(input logic [3:0] r, input logic i, input logic s);
    bar_req   = r;
    mem_issue = i;
    mem_rsp   = s;
    @(posedge clk);
    #1;
    bar_req   = '0;
    mem_issue = 1'b0;
    mem_rsp   = 1'b0;
  endtask

  task automatic push(input int c, input logic [3:0] d);
    exp_t e;
    e.cyc  = c;
    e.done = d;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t;
    rst = 1'b1;
    bar_req = '0;
    mem_issue = 1'b0;
    mem_rsp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_os", os_cnt, 0);
    chk("rst_rdy", mem_issue_rdy, 1);
    chk("rst_err", err, 0);
    chk("rst_done", bar_done, 0);

    // Idle barrier, thread 1
    t = cyc;
    push(t + 2, 4'b0010);
    cyc1(4'b0010, 0, 0);
    chk("b1_rdy_t1", mem_issue_rdy, 0);
    cyc1(0, 0, 0);
    chk("b1_rdy_t2", mem_issue_rdy, 0);
    cyc1(0, 0, 0);
    chk("b1_rdy_t3", mem_issue_rdy, 1);

    // Three outstanding, thread 3, rsps at +5,+6,+9
    repeat (3) cyc1(0, 1, 0);
    chk("b2_os3", os_cnt, 3);
    t = cyc;
    push(t + 11, 4'b1000);
    cyc1(4'b1000, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      chk("b2_rdy_low", mem_issue_rdy, 0);
      if (k == 10) chk("b2_os0", os_cnt, 0);
      cyc1(0, 0, (k == 5 || k == 6 || k == 9));
    end
    chk("b2_rdy_back", mem_issue_rdy, 1);

    // Issue together with barrier, thread 2
    t = cyc;
    push(t + 6, 4'b0100);
    cyc1(4'b0100, 1, 0);
    chk("b3_os1", os_cnt, 1);
    cyc1(0, 0, 0);
    cyc1(0, 0, 0);
    cyc1(0, 0, 0);
    cyc1(0, 0, 1);
    chk("b3_os0", os_cnt, 0);
    repeat (3) cyc1(0, 0, 0);
    chk("b3_rdy_back", mem_issue_rdy, 1);

    // Simultaneous issue/rsp, then underflow
    cyc1(0, 1, 0);
    cyc1(0, 1, 0);
    cyc1(0, 1, 1);
    chk("simul_os2", os_cnt, 2);
    cyc1(0, 0, 1);
    cyc1(0, 0, 1);
    chk("drain_err", err, 0);
    cyc1(0, 0, 1);
    chk("uf_os", os_cnt, 0);
    chk("uf_err", err, 1);
    repeat (4) cyc1(0, 0, 0);
    chk("uf_sticky", err, 1);

    // Barrier on thread 0 with sticky error present
    t = cyc;
    push(t + 2, 4'b0001);
    cyc1(4'b0001, 0, 0);
    repeat (2) cyc1(0, 0, 0);

    // Saturation
    repeat (63) cyc1(0, 1, 0);
    chk("sat_os", os_cnt, 63);
    chk("sat_rdy", mem_issue_rdy, 0);
    cyc1(0, 0, 1);
    chk("sat_dec", os_cnt, 62);
    chk("sat_rdy_back", mem_issue_rdy, 1);
    repeat (62) cyc1(0, 0, 1);
    chk("sat_empty", os_cnt, 0);

`ifdef DMA_BAR_TIMEOUT_EN
    cyc1(0, 1, 0);
    t = cyc;
    push(t + 18, 4'b0010);
    cyc1(4'b0010, 0, 0);
    repeat (18) cyc1(0, 0, 0);
    chk("to_err1", err[1], 1);
    cyc1(0, 0, 1);
`endif

    // Reset while draining five outstanding
    repeat (5) cyc1(0, 1, 0);
    cyc1(4'b0100, 0, 0);
    repeat (3) cyc1(0, 0, 0);
    chk("rd_os5", os_cnt, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rd_os0", os_cnt, 0);
    chk("rd_rdy", mem_issue_rdy, 1);
    chk("rd_err", err, 0);
    repeat (10) cyc1(0, 0, 0);

    chk("q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
